// File: rtl/output_classifier_pkg.sv
// Shared fixed-point format for the network output vector and the classifier result.
package output_classifier_pkg;
  localparam int INTEGER_WIDTH  = 8;
  localparam int FRACTION_WIDTH = 8;

  typedef logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] fixed_t;
endpackage

// File: rtl/output_classifier.sv
// Snapshots the network output vector and scans it one element per cycle for the argmax.
// Optional confidence flag against a threshold input: define OUTPUT_CLASSIFIER_THRESHOLD_EN.
module output_classifier
  import output_classifier_pkg::*;
#(
  parameter int NUM_OUTPUTS = 10,
  localparam int INDEX_WIDTH = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              outputs_ready,
  input  fixed_t [NUM_OUTPUTS-1:0]          outputs,
  output logic                              busy,
  output logic                              class_valid,
  input  logic                              class_ack,
  output logic [INDEX_WIDTH-1:0]            class_index,
  output fixed_t                            class_value
`ifdef OUTPUT_CLASSIFIER_THRESHOLD_EN
  ,
  input  fixed_t                            threshold,
  output logic                              class_confident
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [INDEX_WIDTH-1:0] FIRST_IDX = INDEX_WIDTH'(1);
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX  = INDEX_WIDTH'(NUM_OUTPUTS - 1);

  state_t                   state;
  fixed_t [NUM_OUTPUTS-1:0] snapshot;
  fixed_t                   best_value;
  logic [INDEX_WIDTH-1:0]   best_index;
  logic [INDEX_WIDTH-1:0]   idx;

  logic                     capture;
  logic                     better;
  logic                     last;
  fixed_t                   next_value;
  logic [INDEX_WIDTH-1:0]   next_index;

  // A new vector is taken from IDLE, or from DONE on the same edge the result is acked.
  always_comb begin
    capture    = outputs_ready && (state == IDLE || (state == DONE && class_ack));
    better     = snapshot[idx] > best_value;
    next_value = better ? snapshot[idx] : best_value;
    next_index = better ? idx : best_index;
    last       = (idx == LAST_IDX);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      class_valid <= 1'b0;
      class_index <= '0;
      class_value <= '0;
      snapshot    <= '0;
      best_value  <= '0;
      best_index  <= '0;
      idx         <= '0;
`ifdef OUTPUT_CLASSIFIER_THRESHOLD_EN
      class_confident <= 1'b0;
`endif
    end else if (capture) begin
      snapshot   <= outputs;
      best_value <= outputs[0];
      best_index <= '0;
      idx        <= FIRST_IDX;
      busy       <= 1'b1;
      if (NUM_OUTPUTS == 1) begin
        // Single-element vector: the capture edge is also the DONE-entry edge.
        state       <= DONE;
        class_valid <= 1'b1;
        class_index <= '0;
        class_value <= outputs[0];
`ifdef OUTPUT_CLASSIFIER_THRESHOLD_EN
        class_confident <= (outputs[0] >= threshold);
`endif
      end else begin
        state       <= SCAN;
        class_valid <= 1'b0;
      end
    end else begin
      case (state)
        SCAN: begin
          best_value <= next_value;
          best_index <= next_index;
          if (last) begin
            state       <= DONE;
            class_valid <= 1'b1;
            class_index <= next_index;
            class_value <= next_value;
`ifdef OUTPUT_CLASSIFIER_THRESHOLD_EN
            class_confident <= (next_value >= threshold);
`endif
          end else begin
            idx <= idx + FIRST_IDX;
          end
        end
        DONE: begin
          if (class_ack) begin
            state       <= IDLE;
            busy        <= 1'b0;
            class_valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_classifier.sv
// Directed + randomized bench for output_classifier against an argmax reference model.
module tb_output_classifier;
  import output_classifier_pkg::*;

  localparam int NUM = 10;
  localparam int IW  = $clog2(NUM);

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              outputs_ready = 1'b0;
  fixed_t [NUM-1:0]  outputs = '0;
  logic              busy;
  logic              class_valid;
  logic              class_ack = 1'b0;
  logic [IW-1:0]     class_index;
  fixed_t            class_value;
`ifdef OUTPUT_CLASSIFIER_THRESHOLD_EN
  fixed_t            threshold = fixed_t'(128);
  logic              class_confident;
`endif

  int vectors    = 0;
  int miscompares = 0;
  int cur [NUM];

  output_classifier #(.NUM_OUTPUTS(NUM)) dut (
    .clock(clock),
    .reset(reset),
    .outputs_ready(outputs_ready),
    .outputs(outputs),
    .busy(busy),
    .class_valid(class_valid),
    .class_ack(class_ack),
    .class_index(class_index),
    .class_value(class_value)
`ifdef OUTPUT_CLASSIFIER_THRESHOLD_EN
    ,
    .threshold(threshold),
    .class_confident(class_confident)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: largest value first, then the lowest index holding it.
  task automatic model(output int ei, output int ev);
    ev = cur[0];
    foreach (cur[i]) if (cur[i] > ev) ev = cur[i];
    ei = 0;
    for (int i = NUM - 1; i >= 0; i--) if (cur[i] == ev) ei = i;
  endtask

  task automatic drive_cur();
    for (int i = 0; i < NUM; i++) outputs[i] = fixed_t'(cur[i]);
  endtask

  // Pulse outputs_ready across one edge E; returns at the negedge after E.
  task automatic start_vector();
    @(negedge clock);
    drive_cur();
    outputs_ready = 1'b1;
    @(negedge clock);
    outputs_ready = 1'b0;
  endtask

  // k = number of edges past E when class_valid is first seen.
  task automatic wait_valid(output int k);
    k = 0;
    while (!class_valid && k < 40) begin
      @(negedge clock);
      k++;
    end
  endtask

  task automatic check_result(input string tag, input int k);
    int ei, ev;
    model(ei, ev);
    check({tag, "_lat"}, k, NUM - 1);
    check({tag, "_valid"}, class_valid, 1);
    check({tag, "_index"}, class_index, ei);
    check({tag, "_value"}, class_value, ev);
  endtask

  task automatic random_vector();
    bit narrow;
    narrow = $urandom_range(0, 1) == 1;
    foreach (cur[i])
      cur[i] = narrow ? (int'($urandom_range(0, 7)) - 4) * 64
                      : int'($urandom_range(0, 65535)) - 32768;
  endtask

  task automatic fill(input int base);
    foreach (cur[i]) cur[i] = base;
  endtask

  initial begin
    int k, si, sv;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_valid", class_valid, 0);
    check("rst_index", class_index, 0);
    check("rst_value", class_value, 0);
    reset = 1'b0;

    // Basic: max 0.9 at index 2, ack held high -> valid for exactly one cycle
    class_ack = 1'b1;
    cur = '{26, 51, 230, 77, 0, 0, 0, 0, 0, -256};
    start_vector();
    check("basic_busy", busy, 1);
    wait_valid(k);
    check_result("basic", k);
    @(negedge clock);
    check("basic_pulse_valid", class_valid, 0);
    check("basic_pulse_busy", busy, 0);

    // Ties and negatives: lowest index of -0.5 wins
    fill(-512);
    cur[4] = -128;
    cur[7] = -128;
    start_vector();
    wait_valid(k);
    check_result("tie", k);
    @(negedge clock);
    class_ack = 1'b0;

    // Backpressure: result held, ready pulse during DONE dropped
    cur = '{10, 20, 30, 40, 50, 60, 700, 80, 90, 100};
    start_vector();
    wait_valid(k);
    check_result("bp", k);
    si = class_index;
    sv = class_value;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (c == 5) begin
        fill(0);
        cur[1] = 5000;
        drive_cur();
        outputs_ready = 1'b1;
      end else begin
        outputs_ready = 1'b0;
      end
      check("bp_valid_hold", class_valid, 1);
      check("bp_index_hold", class_index, si);
      check("bp_value_hold", class_value, sv);
    end
    class_ack = 1'b1;
    @(negedge clock);
    class_ack = 1'b0;
    check("bp_ack_valid", class_valid, 0);
    check("bp_ack_busy", busy, 0);
    @(negedge clock);
    check("bp_drop_busy", busy, 0);
    check("bp_drop_valid", class_valid, 0);

    // Back-to-back: ack and new vector on the same edge
    random_vector();
    start_vector();
    wait_valid(k);
    check_result("b2b_a", k);
    fill(-300);
    cur[9] = 1000;
    cur[3] = 999;
    drive_cur();
    outputs_ready = 1'b1;
    class_ack = 1'b1;
    @(negedge clock);
    outputs_ready = 1'b0;
    class_ack = 1'b0;
    check("b2b_busy", busy, 1);
    check("b2b_valid_low", class_valid, 0);
    wait_valid(k);
    check_result("b2b_b", k);
    class_ack = 1'b1;
    @(negedge clock);
    class_ack = 1'b0;

    // Reset mid-SCAN at idx=5: asynchronous clear before the next edge
    random_vector();
    start_vector();
    repeat (4) @(negedge clock);
    check("mid_busy_pre", busy, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", class_valid, 0);
    check("mid_rst_index", class_index, 0);
    check("mid_rst_value", class_value, 0);
    @(negedge clock);
    reset = 1'b0;
    random_vector();
    start_vector();
    wait_valid(k);
    check_result("post_rst", k);
    class_ack = 1'b1;
    @(negedge clock);
    class_ack = 1'b0;

    // Randomized vectors with random ack delay
    for (int n = 0; n < 25; n++) begin
      int d;
      random_vector();
      start_vector();
      wait_valid(k);
      check_result("rnd", k);
      d = $urandom_range(0, 3);
      repeat (d) @(negedge clock);
      check("rnd_hold", class_valid, 1);
      class_ack = 1'b1;
      @(negedge clock);
      class_ack = 1'b0;
      check("rnd_ack", class_valid, 0);
    end

`ifdef OUTPUT_CLASSIFIER_THRESHOLD_EN
    // Threshold 0.5: max 0.9 / 0.5 / 0.4
    threshold = fixed_t'(128);
    for (int t = 0; t < 3; t++) begin
      int mx;
      mx = (t == 0) ? 230 : (t == 1) ? 128 : 102;
      fill(0);
      cur[3] = mx;
      start_vector();
      wait_valid(k);
      check_result("thr", k);
      check("thr_confident", class_confident, (mx >= 128) ? 1 : 0);
      class_ack = 1'b1;
      @(negedge clock);
      class_ack = 1'b0;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
